// File: rtl/cpu_pkg.sv
// cpu_pkg: shared cpu types and defaults
package cpu_pkg;
  typedef enum logic {RUN, HALT} fetch_state_e;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: if/id pipeline register with hold and flush
module ifid_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  logic        valid_q, valid_d;
  always_comb begin
    instr_d = flush ? NOP_WORD : hold ? instr_q : instr_in;
    pc4_d   = (flush || hold) ? pc4_q : pc4_in;
    valid_d = !flush && (hold ? valid_q : 1'b1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end
  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: pc sequencing and fetch from an external rom into if/id
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_BYTES = 64,
  parameter logic [31:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic [31:0] romAddr,
  input  logic [31:0] romData,
  output logic [31:0] ifidInstr,
  output logic [31:0] ifidPc4,
  output logic        ifidValid,
  output logic        halted,
  output logic        misalign,
  output logic [15:0] fetchCount
);
  localparam logic [31:0] ROM_LAST = 32'(ROM_BYTES - 4);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         misalign_q, misalign_d;
  logic [15:0]  count_q, count_d;
  logic         oob, run, capture, flush;
  always_comb begin
    oob        = pc_q > ROM_LAST;
    run        = state_q == RUN;
    capture    = !redirect && !stall && run && !oob;
    flush      = redirect || (!stall && (!run || oob));
    pc_d       = redirect ? {redirectPc[31:2], 2'b00} : capture ? pc_q + 32'd4 : pc_q;
    state_d    = redirect ? RUN : (!stall && run && oob) ? HALT : state_q;
    misalign_d = misalign_q || (redirect && |redirectPc[1:0]);
    count_d    = (capture && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      state_q    <= RUN;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end
  ifid_reg #(.NOP_WORD(NOP_WORD)) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .hold     (stall),
    .flush    (flush),
    .instr_in (romData),
    .pc4_in   (pc_q + 32'd4),
    .instr    (ifidInstr),
    .pc4      (ifidPc4),
    .valid    (ifidValid)
  );
  assign romAddr    = pc_q;
  assign halted     = state_q == HALT;
  assign misalign   = misalign_q;
  assign fetchCount = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a behavioural rom
module tb_instr_fetch;
  import cpu_pkg::*;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, rom_addr, rom_data, ifid_instr, ifid_pc4;
  logic        ifid_valid, halted, misalign;
  logic [15:0] fetch_count;
  logic [31:0] rom [16];
  exp_t        sb [$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_halt, m_mis, m_valid;
  logic [15:0] m_cnt;
  always #5 clk = ~clk;
  assign rom_data = (rom_addr < 32'd64) ? rom[rom_addr[5:2]] : 32'hDEAD_BEEF;
  instr_fetch #(.RESET_PC(32'h0), .ROM_BYTES(64), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirectPc (redirect_pc),
    .romAddr    (rom_addr),
    .romData    (rom_data),
    .ifidInstr  (ifid_instr),
    .ifidPc4    (ifid_pc4),
    .ifidValid  (ifid_valid),
    .halted     (halted),
    .misalign   (misalign),
    .fetchCount (fetch_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input bit r_st, input bit s, input bit rd, input logic [31:0] t);
    bit   cap = 1'b0;
    exp_t e;
    rst = r_st;
    stall = s;
    redirect = rd;
    redirect_pc = t;
    if (r_st) begin
      m_pc = 32'h0; m_halt = 1'b0; m_mis = 1'b0; m_cnt = '0;
      m_instr = NOP; m_pc4 = '0; m_valid = 1'b0;
      sb.delete();
    end else if (rd) begin
      m_pc = {t[31:2], 2'b00}; m_halt = 1'b0; m_mis = m_mis | (t[1:0] != 2'b00);
      m_instr = NOP; m_valid = 1'b0;
    end else if (s) begin
    end else if (m_halt || m_pc + 32'd4 > 32'd64) begin
      m_instr = NOP; m_valid = 1'b0; m_halt = 1'b1;
    end else begin
      sb.push_back({rom[m_pc[5:2]], m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
      cap = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt++;
    end
    @(posedge clk);
    #1;
    if (cap) begin
      if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        m_instr = e.instr;
        m_pc4 = e.pc4;
      end
    end
    chk("romAddr", rom_addr, m_pc);
    chk("ifidInstr", ifid_instr, m_instr);
    chk("ifidPc4", ifid_pc4, m_pc4);
    chk("ifidValid", 32'(ifid_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("fetchCount", 32'(fetch_count), 32'(m_cnt));
  endtask
  initial begin
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h2009_000A;
    for (int i = 2; i < 16; i++) rom[i] = 32'h3000_0000 + 32'(i * 32'h111);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 32'h20);
    cyc(0, 0, 0, 0);
    chk("first_word", ifid_instr, 32'h2008_0005);
    cyc(0, 0, 0, 0);
    chk("second_word", ifid_instr, 32'h2009_000A);
    chk("count_two", 32'(fetch_count), 32'd2);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h10);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 32'h13);
    cyc(0, 0, 1, 32'h13);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0);
    chk("halt_count", 32'(fetch_count), 32'd16);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h3C);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h40);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h3F);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 80; i++)
      cyc(0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 32'($urandom_range(0, 32'h4F)));
    cyc(1, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
